// File: rtl/dmem_pkg.sv
// Shared definitions for the nano RV32I data-memory responder: MMIO offsets,
// region select and the byte-lane merge helper.
package dmem_pkg;

  localparam logic [1:0] MMIO_GPIO  = 2'd0;
  localparam logic [1:0] MMIO_CYCLE = 2'd1;
  localparam logic [1:0] MMIO_CTRL  = 2'd2;

  localparam logic [31:0] CTRL_RST = 32'h0000_0001;

  typedef enum logic [1:0] {
    REG_RAM  = 2'd0,
    REG_MMIO = 2'd1,
    REG_NONE = 2'd2
  } region_e;

  // Replace only the byte lanes selected by we, keep the others.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  we);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (we[b]) begin
        res[8*b +: 8] = new_word[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_word[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_mmio.sv
// MMIO window of the data-memory responder: GPIO output register, CTRL
// enable bit and the free-running CYCLE counter.
module dmem_mmio
  import dmem_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        sel,
  input  logic [1:0]  off,
  input  logic [3:0]  we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] gpio_o
);

  logic [31:0] gpio_r;
  logic [31:0] cycle_r;
  logic        ctrl_en_r;
  logic        wr_s;

  assign wr_s   = sel && (we != 4'h0);
  assign gpio_o = gpio_r;

  // Register updates; a CYCLE write suppresses that cycle's increment.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      gpio_r    <= 32'h0000_0000;
      cycle_r   <= 32'h0000_0000;
      ctrl_en_r <= CTRL_RST[0];
    end else begin
      if (wr_s && (off == MMIO_GPIO)) begin
        gpio_r <= lane_merge(gpio_r, wdata, we);
      end
      if (wr_s && (off == MMIO_CYCLE)) begin
        cycle_r <= lane_merge(cycle_r, wdata, we);
      end else if (ctrl_en_r) begin
        cycle_r <= cycle_r + 32'd1;
      end
      if (wr_s && (off == MMIO_CTRL) && we[0]) begin
        ctrl_en_r <= wdata[0];
      end
    end
  end

  // Read mux over the current (pre-edge) register values.
  always_comb begin
    rdata = 32'h0000_0000;
    case (off)
      MMIO_GPIO:  rdata = gpio_r;
      MMIO_CYCLE: rdata = cycle_r;
      MMIO_CTRL:  rdata = {31'h0, ctrl_en_r};
      default:    rdata = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the nano RV32I core: address decode, byte-lane RAM,
// registered read data and error pulse. MMIO window built only with DMEM_MMIO_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] RAM_BASE    = 32'h0000_0000,
  parameter logic [31:0] MMIO_BASE   = 32'h1000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_data_i,
  input  logic        d_rd_i,
  input  logic [3:0]  d_we_i,
  output logic [31:0] d_data_o,
  output logic        err_o,
  output logic [31:0] gpio_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

`ifdef DMEM_MMIO_EN
  localparam bit MMIO_EN = 1'b1;
`else
  localparam bit MMIO_EN = 1'b0;
`endif

  logic [31:0]   mem_r [DEPTH_WORDS];
  logic [31:0]   d_data_r;
  logic          err_r;
  region_e       region_s;
  logic [AW-1:0] idx_s;
  logic [31:0]   rdata_s;
  logic [31:0]   mmio_rdata_s;
  logic          mmio_sel_s;
  logic          unused_s;

  assign idx_s      = d_addr_i[AW+1:2];
  assign mmio_sel_s = (region_s == REG_MMIO);
  assign d_data_o   = d_data_r;
  assign err_o      = err_r;
  assign unused_s   = ^d_addr_i[1:0];

  // RAM base is size-aligned, so a prefix compare equals the range check.
  always_comb begin
    region_s = REG_NONE;
    if (d_addr_i[31:AW+2] == RAM_BASE[31:AW+2]) begin
      region_s = REG_RAM;
    end else if (MMIO_EN && (d_addr_i[31:4] == MMIO_BASE[31:4])) begin
      region_s = REG_MMIO;
    end else begin
      region_s = REG_NONE;
    end
  end

  // Read mux; unmapped addresses read as zero.
  always_comb begin
    rdata_s = 32'h0000_0000;
    case (region_s)
      REG_RAM:  rdata_s = mem_r[idx_s];
      REG_MMIO: rdata_s = mmio_rdata_s;
      default:  rdata_s = 32'h0000_0000;
    endcase
  end

  // RAM byte-lane writes; contents are not reset, and a write is dropped under reset.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && (region_s == REG_RAM)) begin
      for (int b = 0; b < 4; b++) begin
        if (d_we_i[b]) begin
          mem_r[idx_s][8*b +: 8] <= d_data_i[8*b +: 8];
        end
      end
    end
  end

  // Output registers: read data holds between reads, error pulses for one cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      d_data_r <= 32'h0000_0000;
      err_r    <= 1'b0;
    end else begin
      if (d_rd_i) begin
        d_data_r <= rdata_s;
      end
      err_r <= (region_s == REG_NONE) && (d_rd_i || (d_we_i != 4'h0));
    end
  end

`ifdef DMEM_MMIO_EN
  dmem_mmio u_mmio (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .sel     (mmio_sel_s),
    .off     (d_addr_i[3:2]),
    .we      (d_we_i),
    .wdata   (d_data_i),
    .rdata   (mmio_rdata_s),
    .gpio_o  (gpio_o)
  );
`else
  assign mmio_rdata_s = 32'h0000_0000;
  assign gpio_o       = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: behavioural memory/MMIO model compared
// every cycle, plus hand-computed expectations on the directed sequence.
module tb_dmem_responder;

  localparam int unsigned DEPTH     = 1024;
  localparam logic [31:0] RAM_BASE  = 32'h0000_0000;
  localparam logic [31:0] MMIO_BASE = 32'h1000_0000;
`ifdef DMEM_MMIO_EN
  localparam bit MMIO_EN = 1'b1;
`else
  localparam bit MMIO_EN = 1'b0;
`endif

  logic        clk_i    = 1'b0;
  logic        rst_n_i  = 1'b0;
  logic [31:0] d_addr_i = 32'h0;
  logic [31:0] d_data_i = 32'h0;
  logic        d_rd_i   = 1'b0;
  logic [3:0]  d_we_i   = 4'h0;
  logic [31:0] d_data_o;
  logic        err_o;
  logic [31:0] gpio_o;

  int n_checks = 0;
  int n_pass   = 0;
  bit check_en = 1'b0;

  always #5 clk_i = ~clk_i;

  dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .RAM_BASE    (RAM_BASE),
    .MMIO_BASE   (MMIO_BASE)
  ) dut (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .d_addr_i (d_addr_i),
    .d_data_i (d_data_i),
    .d_rd_i   (d_rd_i),
    .d_we_i   (d_we_i),
    .d_data_o (d_data_o),
    .err_o    (err_o),
    .gpio_o   (gpio_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [int];
  logic [31:0] exp_data  = 32'h0;
  bit          exp_known = 1'b1;
  logic        exp_err   = 1'b0;
  logic [31:0] m_gpio    = 32'h0;
  logic [31:0] m_cycle   = 32'h0;
  logic        m_ctrl    = 1'b1;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  initial begin
    forever begin
      longint unsigned la;
      bit ram_hit, mmio_hit, known, wr;
      int idx;
      logic [31:0] rv;
      logic [1:0] off;
      @(posedge clk_i or negedge rst_n_i);
      if (!rst_n_i) begin
        exp_data = 32'h0; exp_known = 1'b1; exp_err = 1'b0;
        m_gpio = 32'h0; m_cycle = 32'h0; m_ctrl = 1'b1;
      end else begin
        la       = longint'(d_addr_i);
        ram_hit  = (la >= longint'(RAM_BASE)) && (la < longint'(RAM_BASE) + DEPTH * 4);
        mmio_hit = MMIO_EN && !ram_hit && (d_addr_i[31:4] == MMIO_BASE[31:4]);
        idx      = int'(d_addr_i[31:2]);
        off      = d_addr_i[3:2];
        wr       = (d_we_i != 4'h0);
        known    = 1'b1;
        rv       = 32'h0;
        if (ram_hit) begin
          known = m_mem.exists(idx);
          rv    = known ? m_mem[idx] : 32'h0;
        end else if (mmio_hit) begin
          case (off)
            2'd0: rv = m_gpio;
            2'd1: rv = m_cycle;
            2'd2: rv = {31'h0, m_ctrl};
            default: rv = 32'h0;
          endcase
        end
        if (d_rd_i) begin
          exp_data  = rv;
          exp_known = known;
        end
        exp_err = !ram_hit && !mmio_hit && (d_rd_i || wr);
        if (mmio_hit && wr && off == 2'd1) m_cycle = merge(m_cycle, d_data_i, d_we_i);
        else if (m_ctrl) m_cycle = m_cycle + 32'd1;
        if (ram_hit && wr) m_mem[idx] = merge(m_mem.exists(idx) ? m_mem[idx] : 32'h0, d_data_i, d_we_i);
        if (mmio_hit && wr && off == 2'd0) m_gpio = merge(m_gpio, d_data_i, d_we_i);
        if (mmio_hit && off == 2'd2 && d_we_i[0]) m_ctrl = d_data_i[0];
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk_i) begin
    if (check_en) begin
      if (exp_known) check("model_data", d_data_o, exp_data);
      check("model_err", {31'h0, err_o}, {31'h0, exp_err});
      check("model_gpio", gpio_o, m_gpio);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic rd,
                     input logic [3:0] we);
    d_addr_i = a; d_data_i = d; d_rd_i = rd; d_we_i = we;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    cyc(32'h0, 32'h0, 1'b0, 4'h0);
  endtask

  initial begin
    @(posedge clk_i); #1;
    check("reset_data", d_data_o, 32'h0);
    check("reset_err", {31'h0, err_o}, 32'h0);
    check("reset_gpio", gpio_o, 32'h0);
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    check_en = 1'b1;

    cyc(32'h10, 32'hDEAD_BEEF, 1'b0, 4'hF);
    cyc(32'h10, 32'h0, 1'b1, 4'h0);
    check("full_word_read", d_data_o, 32'hDEAD_BEEF);
    check("full_word_err", {31'h0, err_o}, 32'h0);

    cyc(32'h10, 32'h0000_AA00, 1'b0, 4'b0010);
    cyc(32'h10, 32'h0, 1'b1, 4'h0);
    check("lane1_write", d_data_o, 32'hDEAD_AAEF);

    cyc(32'h20, 32'h5, 1'b0, 4'hF);
    cyc(32'h20, 32'h1111_1111, 1'b1, 4'hF);
    check("read_before_write", d_data_o, 32'h5);
    cyc(32'h20, 32'h0, 1'b1, 4'h0);
    check("write_then_read", d_data_o, 32'h1111_1111);
    idle();
    check("hold_no_read", d_data_o, 32'h1111_1111);

    cyc(32'h2000_0000, 32'h0, 1'b1, 4'h0);
    check("unmapped_rd_data", d_data_o, 32'h0);
    check("unmapped_rd_err", {31'h0, err_o}, 32'h1);
    idle();
    check("err_one_cycle", {31'h0, err_o}, 32'h0);
    cyc(32'h2000_0010, 32'hCAFE_F00D, 1'b0, 4'hF);
    check("unmapped_wr_err", {31'h0, err_o}, 32'h1);
    cyc(32'h13, 32'h0, 1'b1, 4'h0);
    check("ram_untouched_lowbits", d_data_o, 32'hDEAD_AAEF);

    cyc(32'h0000_0FFC, 32'h1234_5678, 1'b0, 4'hF);
    cyc(32'h0000_0FFC, 32'h0, 1'b1, 4'h0);
    check("last_word", d_data_o, 32'h1234_5678);
    cyc(32'h0000_1000, 32'h0, 1'b1, 4'h0);
    check("past_end_err", {31'h0, err_o}, 32'h1);
    check("past_end_data", d_data_o, 32'h0);

`ifdef DMEM_MMIO_EN
    cyc(MMIO_BASE + 32'h4, 32'hFFFF_FFFE, 1'b0, 4'hF);
    idle();
    cyc(MMIO_BASE + 32'h4, 32'h0, 1'b1, 4'h0);
    check("cycle_pre_wrap", d_data_o, 32'hFFFF_FFFF);
    cyc(MMIO_BASE + 32'h4, 32'h0, 1'b1, 4'h0);
    check("cycle_wrap", d_data_o, 32'h0);
    cyc(MMIO_BASE + 32'h8, 32'h0, 1'b0, 4'hF);
    cyc(MMIO_BASE + 32'h4, 32'h0, 1'b1, 4'h0);
    check("cycle_frozen_a", d_data_o, 32'h2);
    cyc(MMIO_BASE + 32'h4, 32'h0, 1'b1, 4'h0);
    check("cycle_frozen_b", d_data_o, 32'h2);
    cyc(MMIO_BASE + 32'h8, 32'h0, 1'b1, 4'h0);
    check("ctrl_read", d_data_o, 32'h0);
    cyc(MMIO_BASE, 32'h0000_00A5, 1'b0, 4'hF);
    check("gpio_write", gpio_o, 32'h0000_00A5);
    cyc(MMIO_BASE + 32'hC, 32'hFFFF_FFFF, 1'b1, 4'hF);
    check("reserved_data", d_data_o, 32'h0);
    check("reserved_err", {31'h0, err_o}, 32'h0);
`else
    cyc(MMIO_BASE, 32'h0000_00A5, 1'b0, 4'hF);
    check("mmio_off_wr_err", {31'h0, err_o}, 32'h1);
    check("mmio_off_gpio", gpio_o, 32'h0);
    cyc(MMIO_BASE + 32'h4, 32'h0, 1'b1, 4'h0);
    check("mmio_off_rd_data", d_data_o, 32'h0);
    check("mmio_off_rd_err", {31'h0, err_o}, 32'h1);
`endif

    // Reset in the middle of a cycle carrying a write.
    cyc(32'h10, 32'h0, 1'b1, 4'h0);
    d_addr_i = 32'h10; d_data_i = 32'h0BAD_0BAD; d_rd_i = 1'b0; d_we_i = 4'hF;
    #2;
    rst_n_i = 1'b0;
    #1;
    check("async_rst_data", d_data_o, 32'h0);
    check("async_rst_err", {31'h0, err_o}, 32'h0);
    check("async_rst_gpio", gpio_o, 32'h0);
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
`ifdef DMEM_MMIO_EN
    cyc(MMIO_BASE + 32'h4, 32'h0, 1'b1, 4'h0);
    check("rst_cycle", d_data_o, 32'h0);
    cyc(MMIO_BASE + 32'h8, 32'h0, 1'b1, 4'h0);
    check("rst_ctrl", d_data_o, 32'h1);
`endif
    cyc(32'h10, 32'h0, 1'b1, 4'h0);
    check("rst_write_absent", d_data_o, 32'hDEAD_AAEF);
    idle();
    idle();

    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
